dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: AWIDTH, default 10, memory word address width; DWIDTH, default 32, data width; MAX_LOCK, default 16, maximum consecutive locked grants to port 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0/we0  input  1/1  port 0 (CPU load/store) request and write-enable.
REQ-005 addr0/wdata0  input  AWIDTH/DWIDTH  port 0 address and write data; held stable until gnt0.
REQ-006 gnt0  output  1  port 0 access issued to memory this cycle.
REQ-007 rvalid0/rdata0  output  1/DWIDTH  port 0 read response, one cycle after a granted read.
REQ-008 req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same widths and meanings as port 0, for the debug/loader port.
REQ-009 lock1  input  1  port 1 requests retention of the memory across consecutive accesses (burst).
REQ-010 mem_en/mem_we  output  1/1  memory access strobe and write-enable.
REQ-011 mem_addr/mem_wdata  output  AWIDTH/DWIDTH  memory address and write data.
REQ-012 mem_rdata  input  DWIDTH  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-013 cpu_stall  output  1  high when req0=1 and gnt0=0 in the same cycle.

Function
REQ-014 At most one of gnt0/gnt1 SHALL be high per cycle; gnt is combinational from req and registered arbitration state.
REQ-015 When gntN=1, mem_en=1 and mem_we/mem_addr/mem_wdata SHALL equal portN inputs in that cycle; with no grant, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-016 Every access SHALL complete in one cycle; back-to-back grants are allowed every cycle.
REQ-017 A granted read SHALL produce rvalidN=1 for exactly one cycle, in the cycle after the grant, with rdataN=mem_rdata; rdataN SHALL be 0 when rvalidN=0.
REQ-018 Writes SHALL produce no rvalid.
REQ-019 Registered state SHALL comprise last_gnt (1 bit), lock_cnt (width sufficient to count 0..MAX_LOCK), and resp_port/resp_pend.
REQ-020 Round-robin: with both requests present and no active lock, grant SHALL go to the port not equal to last_gnt; with one request present, that port SHALL be granted.
REQ-021 last_gnt SHALL update to the granted port on every grant and hold otherwise.
REQ-022 Lock: if last_gnt=1, req1=1, lock1=1 and lock_cnt<MAX_LOCK, port 1 SHALL be granted regardless of req0.
REQ-023 lock_cnt SHALL increment on each port-1 grant made while lock1=1.
REQ-024 lock_cnt SHALL clear on any port-0 grant, on any cycle with lock1=0, and on any idle cycle.
REQ-025 When lock_cnt=MAX_LOCK and req0=1, port 0 SHALL be granted for one cycle, clearing lock_cnt; port 1 may then re-lock.
REQ-026 When lock_cnt=MAX_LOCK and req0=0, port 1 SHALL continue to be granted, with lock_cnt saturating at MAX_LOCK.
REQ-027 Deasserting req1 or lock1 SHALL end the lock immediately; the next cycle uses round-robin.

Reset
REQ-028 While rst=1: gnt0=gnt1=0, mem_en=0, rvalid0=rvalid1=0, rdata0=rdata1=0, cpu_stall=0.
REQ-029 Reset SHALL set last_gnt=1 so that port 0 wins the first contention, and SHALL clear lock_cnt to 0.
REQ-030 A read granted in the cycle before rst asserts SHALL NOT produce rvalid.

Configuration
REQ-031 Macro DMEM_ARB_FIXED_PRIO_EN: when defined, port 0 SHALL always win contention; lock1, lock_cnt and REQ-022..REQ-027 SHALL be removed, and port 1 is granted only when req0=0.
REQ-032 When DMEM_ARB_FIXED_PRIO_EN is undefined, the round-robin and lock behaviour of REQ-020..REQ-027 SHALL apply.

Verification
REQ-033 After reset, req0=req1=1 as reads to addr 5 and 9 -> gnt0 in cycle 1, gnt1 in cycle 2; rvalid0 and rvalid1 each one cycle later with the memory contents.
REQ-034 req0 write to addr 3 with data 0xDEADBEEF, then req0 read of addr 3 -> rvalid0=1 with rdata0=0xDEADBEEF two cycles after the write grant; no rvalid on the write.
REQ-035 req1=lock1=1 held, req0=1 from cycle 1, MAX_LOCK=16 -> gnt1 for 16 consecutive cycles, then gnt0 for one cycle; cpu_stall=1 during the stalled cycles.
REQ-036 Read granted to port 1, rst=1 in the next cycle -> rvalid1=0 and all outputs 0 during reset; after release, port 0 wins the first contention.
REQ-037 With DMEM_ARB_FIXED_PRIO_EN defined, req0 and req1 held high for 8 cycles -> gnt0 in all 8 cycles, gnt1 never; lock1 has no effect.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port single-cycle data memory arbiter.
//   Port 0 is the CPU load/store port. Port 1 is the debug/loader port, which
//   can hold the memory for a burst with lock1. A burst is cut short after
//   MAX_LOCK grants whenever port 0 is waiting.
//   Grants are combinational from the requests and the registered arbitration
//   state. Read responses come back one cycle after the grant.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req0/we0/addr0/wdata0            port 0 request, write enable, address, write data
//   gnt0, rvalid0/rdata0             port 0 grant and read response
//   req1/we1/addr1/wdata1/lock1      port 1 request, write enable, address, write data, burst lock
//   gnt1, rvalid1/rdata1             port 1 grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata memory access strobe and payload
//   mem_rdata                        memory read data, one cycle after a read strobe
//   cpu_stall                        port 0 is requesting but not granted
// Configuration macro:
//   DMEM_ARB_FIXED_PRIO_EN  port 0 always wins contention and the lock is removed
module dmem_arbiter #(
  parameter int unsigned AWIDTH   = 10,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DWIDTH-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              cpu_stall
);

  logic resp_pend;
  logic resp_port;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // The lock input is accepted but has no effect in this build.
  logic unused_lock1;
  assign unused_lock1 = lock1;

  // Fixed priority: port 1 only when port 0 is idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = req0;
      gnt1 = req1 && !req0;
    end
  end
`else
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  logic          last_gnt;
  logic [CW-1:0] lock_cnt;
  logic          lock_hold;

  // Port 1 keeps the memory while its burst is under the limit. A nonzero
  // lock_cnt implies port 1 had the last grant, so once the limit is reached
  // round-robin naturally hands the next contended cycle to port 0.
  assign lock_hold = last_gnt && req1 && lock1 && (lock_cnt < CW'(MAX_LOCK));

  // Arbitration: lock first, then round-robin against last_gnt.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (lock_hold) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Arbitration state: last winner and saturating burst length.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      lock_cnt <= '0;
    end else begin
      if (gnt0) begin
        last_gnt <= 1'b0;
      end else if (gnt1) begin
        last_gnt <= 1'b1;
      end
      // Any port-0 grant, unlocked cycle or idle cycle breaks the burst.
      if (gnt1 && lock1) begin
        if (lock_cnt != CW'(MAX_LOCK)) begin
          lock_cnt <= lock_cnt + CW'(1);
        end
      end else begin
        lock_cnt <= '0;
      end
    end
  end
`endif

  // Memory request mux; the bus is driven to zero when nobody is granted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Remember which port owns the read data returning next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_pend <= 1'b0;
      resp_port <= 1'b0;
    end else begin
      resp_pend <= (gnt0 && !we0) || (gnt1 && !we1);
      resp_port <= gnt1;
    end
  end

  // Gating with rst drops a response whose read was granted just before reset.
  always_comb begin
    rvalid0 = !rst && resp_pend && !resp_port;
    rvalid1 = !rst && resp_pend && resp_port;
    rdata0  = rvalid0 ? mem_rdata : '0;
    rdata1  = rvalid1 ? mem_rdata : '0;
  end

  assign cpu_stall = req0 && !gnt0 && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (default build: round-robin with lock,
// MAX_LOCK=16). A simple synchronous memory model answers reads one cycle
// after the strobe.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1, lock1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we, cpu_stall;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AWIDTH(10), .DWIDTH(32), .MAX_LOCK(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .rvalid0   (rvalid0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .lock1     (lock1),
    .gnt1      (gnt1),
    .rvalid1   (rvalid1),
    .rdata1    (rdata1),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall)
  );

  // Memory model: one-cycle read latency, write on strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, settle, then check.
  task automatic cyc(input logic r, input logic r0, input logic w0, input logic [9:0] a0,
                     input logic [31:0] d0, input logic r1, input logic w1,
                     input logic [9:0] a1, input logic [31:0] d1, input logic l1);
    @(negedge clk);
    rst = r; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[5] = 32'h5555_0005;
    mem[9] = 32'h9999_0009;
    mem_rdata = 32'd0;
    rst = 1'b1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; lock1 = 0;
    repeat (2) @(posedge clk);

    // Reset holds every output low even with both ports requesting
    cyc(1, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 1);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rdata0", rdata0, 0);

    // First contention after reset goes to port 0
    cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 0);
    chk("c1_gnt0", gnt0, 1);
    chk("c1_gnt1", gnt1, 0);
    chk("c1_mem_en", mem_en, 1);
    chk("c1_mem_we", mem_we, 0);
    chk("c1_mem_addr", mem_addr, 5);
    chk("c1_stall", cpu_stall, 0);
    cyc(0, 0, 0, 10'd0, 32'd0, 1, 0, 10'd9, 32'd0, 0);
    chk("c2_gnt1", gnt1, 1);
    chk("c2_gnt0", gnt0, 0);
    chk("c2_mem_addr", mem_addr, 9);
    chk("c2_rvalid0", rvalid0, 1);
    chk("c2_rdata0", rdata0, 32'h5555_0005);
    idle();
    chk("c3_rvalid1", rvalid1, 1);
    chk("c3_rdata1", rdata1, 32'h9999_0009);
    chk("c3_rvalid0", rvalid0, 0);
    chk("c3_rdata0", rdata0, 0);
    chk("c3_mem_en", mem_en, 0);
    chk("c3_mem_addr", mem_addr, 0);
    chk("c3_mem_wdata", mem_wdata, 0);

    // Write then read back on port 0
    cyc(0, 1, 1, 10'd3, 32'hDEAD_BEEF, 0, 0, 10'd0, 32'd0, 0);
    chk("wr_gnt0", gnt0, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 3);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_rvalid1", rvalid1, 0);
    cyc(0, 1, 0, 10'd3, 32'd0, 0, 0, 10'd0, 32'd0, 0);
    chk("rd_gnt0", gnt0, 1);
    chk("wr_no_rvalid", rvalid0, 0);
    idle();
    chk("rd_rvalid0", rvalid0, 1);
    chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);

    // Round-robin: port 0 won last, so port 1 wins, then port 0
    cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 0);
    chk("rr1_gnt1", gnt1, 1);
    chk("rr1_gnt0", gnt0, 0);
    chk("rr1_stall", cpu_stall, 1);
    cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 0);
    chk("rr2_gnt0", gnt0, 1);
    chk("rr2_gnt1", gnt1, 0);
    chk("rr2_stall", cpu_stall, 0);
    chk("rr2_rvalid1", rvalid1, 1);
    chk("rr2_rdata1", rdata1, 32'h9999_0009);
    idle();
    chk("rr3_rvalid0", rvalid0, 1);
    chk("rr3_rdata0", rdata0, 32'h5555_0005);

    // Lock: 16 port-1 grants while port 0 stalls, then one port-0 grant
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 1);
      chk($sformatf("lock_gnt1_%0d", i), gnt1, 1);
      chk($sformatf("lock_stall_%0d", i), cpu_stall, 1);
    end
    cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 1);
    chk("lock_brk_gnt0", gnt0, 1);
    chk("lock_brk_gnt1", gnt1, 0);
    chk("lock_brk_stall", cpu_stall, 0);
    cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 1);
    chk("relock_gnt1", gnt1, 1);
    // Dropping lock1 ends the burst at once
    cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 0);
    chk("unlock_gnt0", gnt0, 1);
    chk("unlock_gnt1", gnt1, 0);

    // Saturation: 33 uncontended locked grants, then port 0 still breaks in
    for (int i = 0; i < 33; i++) begin
      cyc(0, 0, 0, 10'd0, 32'd0, 1, 0, 10'd9, 32'd0, 1);
      chk($sformatf("sat_gnt1_%0d", i), gnt1, 1);
    end
    cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 1);
    chk("sat_brk_gnt0", gnt0, 1);
    chk("sat_brk_gnt1", gnt1, 0);
    idle();

    // Read to port 1 followed by reset: response is dropped
    cyc(0, 0, 0, 10'd0, 32'd0, 1, 0, 10'd9, 32'd0, 0);
    chk("pre_rst_gnt1", gnt1, 1);
    cyc(1, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 1);
    chk("in_rst_rvalid1", rvalid1, 0);
    chk("in_rst_rdata1", rdata1, 0);
    chk("in_rst_gnt0", gnt0, 0);
    chk("in_rst_gnt1", gnt1, 0);
    chk("in_rst_mem_en", mem_en, 0);
    chk("in_rst_stall", cpu_stall, 0);
    cyc(1, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 1);
    chk("in_rst2_rvalid1", rvalid1, 0);
    cyc(0, 1, 0, 10'd5, 32'd0, 1, 0, 10'd9, 32'd0, 0);
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_gnt1", gnt1, 0);
    chk("post_rst_rvalid1", rvalid1, 0);
    idle();
    chk("post_rst_rvalid0", rvalid0, 1);
    chk("post_rst_rdata0", rdata0, 32'h5555_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
